// File: rtl/uart_drain_pkg.sv
// Shared types and constants for the UART-side FIFO burst drainer.
package uart_drain_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned WORD_W  = 16;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned UPR_W   = 8;
  localparam int unsigned CH_W    = 2;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_HDR  = 3'd1;
  localparam state_t S_RD   = 3'd2;
  localparam state_t S_LAT  = 3'd3;
  localparam state_t S_HI   = 3'd4;
  localparam state_t S_LO   = 3'd5;
  localparam state_t S_DONE = 3'd6;

  localparam int unsigned UART_CH_MAX   = 3;
  localparam int unsigned BURST_LEN_DEF = 1024;
  localparam logic [3:0]  HDR_TAG_DEF   = 4'hA;

endpackage

// File: rtl/edge_detect_rise.sv
// Registered rising-edge detector; stays quiet on the first cycle after reset
// so a level already high at reset release is not reported as an edge.
module edge_detect_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);

  logic arm_q;
  logic prev_q;
  logic rise_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_q  <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      arm_q  <= 1'b1;
      prev_q <= d_i;
      rise_q <= arm_q & d_i & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/uart_fifo_drain.sv
// Drains one burst from the UART-routed FIFO: a header byte, then each word
// high byte first, with abort when the channel select moves away.
module uart_fifo_drain
  import uart_drain_pkg::*;
#(
  parameter int unsigned BURST_LEN = BURST_LEN_DEF,
  parameter logic [3:0]  HDR_TAG   = HDR_TAG_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [UPR_W-1:0]  upr,
  input  logic              fifo_full_uart,
  input  logic [WORD_W-1:0] uart_out,
  input  logic              drain_req,
  input  logic              tx_ready,
  output logic              uart_fifo_rd_en,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  output logic              busy,
  output logic              done,
  output logic              abort,
  output logic [WORD_W-1:0] words_sent
);

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [WORD_W-1:0] words_q, words_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              abort_q, abort_d;

  logic full_rise;
  logic ch_valid;
  logic abort_hit;
  logic xfer;
  logic last_word;

  edge_detect_rise u_full_edge (
    .clk    (clk),
    .rst_n  (rst),
    .d_i    (fifo_full_uart),
    .rise_o (full_rise)
  );

  assign ch_valid  = (upr <= UPR_W'(UART_CH_MAX));
  assign abort_hit = (state_q != S_IDLE) && (upr != UPR_W'(ch_q));
  assign xfer      = tx_valid & tx_ready;
  assign last_word = ((32'(words_q) + 32'd1) == BURST_LEN);

  // Next-state and datapath update; abort overrides any transfer-driven move.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    word_d  = word_q;
    words_d = words_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    abort_d = 1'b0;

    if (abort_hit) begin
      state_d = S_IDLE;
      abort_d = 1'b1;
      busy_d  = 1'b0;
      if ((state_q == S_LO) && xfer) begin
        words_d = words_q + 16'd1;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ch_valid && (drain_req || full_rise)) begin
            state_d = S_HDR;
            ch_d    = upr[CH_W-1:0];
            words_d = '0;
            busy_d  = 1'b1;
          end
        end
        S_HDR: begin
          if (xfer) state_d = S_RD;
        end
        S_RD: begin
          state_d = S_LAT;
        end
        S_LAT: begin
          word_d  = uart_out;
          state_d = S_HI;
        end
        S_HI: begin
          if (xfer) state_d = S_LO;
        end
        S_LO: begin
          if (xfer) begin
            words_d = words_q + 16'd1;
            if (last_word) begin
              state_d = S_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = S_RD;
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      word_q  <= '0;
      words_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      word_q  <= word_d;
      words_q <= words_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  // Byte and strobe decode from the state register; the strobe is suppressed
  // in an abort cycle so a cancelled burst never pops the FIFO.
  always_comb begin
    tx_valid        = 1'b0;
    tx_data         = '0;
    uart_fifo_rd_en = 1'b0;
    case (state_q)
      S_HDR: begin
        tx_valid = 1'b1;
        tx_data  = {HDR_TAG, 2'b00, ch_q};
      end
      S_RD: begin
        uart_fifo_rd_en = ~abort_hit;
      end
      S_HI: begin
        tx_valid = 1'b1;
        tx_data  = word_q[15:8];
      end
      S_LO: begin
        tx_valid = 1'b1;
        tx_data  = word_q[7:0];
      end
      default: begin
        tx_valid = 1'b0;
      end
    endcase
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign abort      = abort_q;
  assign words_sent = words_q;

endmodule

// File: tb/tb_uart_fifo_drain.sv
// Directed plus randomized bench for uart_fifo_drain against a byte-stream model.
module tb_uart_fifo_drain;

  localparam int unsigned BL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  upr = 8'd0;
  logic        fifo_full_uart = 1'b0;
  logic [15:0] uart_out = 16'd0;
  logic        drain_req = 1'b0;
  logic        tx_ready = 1'b1;
  logic        uart_fifo_rd_en;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic        done;
  logic        abort;
  logic [15:0] words_sent;

  uart_fifo_drain #(.BURST_LEN(BL), .HDR_TAG(4'hA)) dut (
    .clk             (clk),
    .rst             (rst),
    .upr             (upr),
    .fifo_full_uart  (fifo_full_uart),
    .uart_out        (uart_out),
    .drain_req       (drain_req),
    .tx_ready        (tx_ready),
    .uart_fifo_rd_en (uart_fifo_rd_en),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .busy            (busy),
    .done            (done),
    .abort           (abort),
    .words_sent      (words_sent)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] fifo_q[$];
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  logic [15:0] burst_w [BL];

  int rd_cnt = 0, done_cnt = 0, abort_cnt = 0, unstable = 0;
  int rd0 = 0, done0 = 0, abort0 = 0, got0 = 0, unst0 = 0;
  int ready_mode = 0;
  int cyc = 0;
  bit chk_stable = 1'b0;
  bit prev_stall = 1'b0;
  logic [7:0] prev_data = 8'd0;

  // FIFO with one-cycle read latency
  always @(posedge clk) begin
    if (uart_fifo_rd_en) begin
      rd_cnt++;
      if (fifo_q.size() > 0) uart_out <= fifo_q.pop_front();
      else uart_out <= 16'h0000;
    end
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    case (ready_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = (cyc % 4 == 0);
      2:       tx_ready = 1'($urandom_range(0, 1));
      default: tx_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (rst) begin
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      if (done) done_cnt++;
      if (abort) abort_cnt++;
      if (chk_stable && prev_stall && !(tx_valid && tx_data == prev_data)) unstable++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic mark();
    rd0 = rd_cnt; done0 = done_cnt; abort0 = abort_cnt; got0 = got_q.size(); unst0 = unstable;
  endtask

  task automatic rand_words();
    for (int i = 0; i < BL; i++) burst_w[i] = 16'($urandom);
  endtask

  // Expected stream: header {A, 00, ch}, then each word high byte first
  task automatic make_exp(input logic [1:0] c);
    exp_q.delete();
    fifo_q.delete();
    exp_q.push_back({4'hA, 2'b00, c});
    for (int i = 0; i < BL; i++) begin
      fifo_q.push_back(burst_w[i]);
      exp_q.push_back(burst_w[i][15:8]);
      exp_q.push_back(burst_w[i][7:0]);
    end
  endtask

  task automatic pulse_req();
    @(posedge clk); #1 drain_req = 1'b1;
    @(posedge clk); #1 drain_req = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    int d0;
    n = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 32'(n < 400), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_bytes(input string tag, input int n);
    logic [7:0] g;
    check({tag, "_nbytes"}, 32'(got_q.size() - got0), 32'(n));
    for (int i = 0; i < n; i++) begin
      g = 'x;
      if (got0 + i < got_q.size()) g = got_q[got0 + i];
      check({tag, "_byte"}, 32'(g), 32'(exp_q[i]));
    end
  endtask

  task automatic check_full_burst(input string tag);
    check_bytes(tag, 1 + 2 * BL);
    check({tag, "_rd"}, 32'(rd_cnt - rd0), 32'(BL));
    check({tag, "_words"}, 32'(words_sent), 32'(BL));
    check({tag, "_done"}, 32'(done_cnt - done0), 32'd1);
    check({tag, "_abort"}, 32'(abort_cnt - abort0), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;

    // reset held with triggers active
    rst = 1'b0; upr = 8'd2; fifo_full_uart = 1'b1; drain_req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_abort", 32'(abort), 32'd0);
    check("rst_rd_en", 32'(uart_fifo_rd_en), 32'd0);
    check("rst_words", 32'(words_sent), 32'd0);
    @(posedge clk); #1 rst = 1'b1; drain_req = 1'b0;
    repeat (6) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_rd", 32'(rd_cnt), 32'd0);
    check("idle_bytes", 32'(got_q.size()), 32'd0);

    // normal burst with start latency check
    burst_w[0] = 16'h1234; burst_w[1] = 16'h5678; burst_w[2] = 16'h9ABC; burst_w[3] = 16'hDEF0;
    make_exp(2'd2);
    mark();
    @(posedge clk); #1 drain_req = 1'b1;
    @(negedge clk);
    check("lat_pre_valid", 32'(tx_valid), 32'd0);
    @(posedge clk); #1 drain_req = 1'b0;
    @(negedge clk);
    check("lat_hdr_valid", 32'(tx_valid), 32'd1);
    check("lat_hdr_data", 32'(tx_data), 32'hA2);
    check("lat_busy", 32'(busy), 32'd1);
    wait_done("norm");
    check_full_burst("norm");
    repeat (5) @(negedge clk);
    check("norm_words_hold", 32'(words_sent), 32'(BL));

    // backpressure: 1 on / 3 off
    make_exp(2'd2);
    mark();
    ready_mode = 1; chk_stable = 1'b1;
    pulse_req();
    wait_done("bp");
    chk_stable = 1'b0; ready_mode = 0;
    check_full_burst("bp");
    check("bp_stable", 32'(unstable - unst0), 32'd0);

    // full-flag edge trigger, drain_req during burst ignored
    fifo_full_uart = 1'b0; upr = 8'd1;
    repeat (3) @(posedge clk);
    rand_words();
    make_exp(2'd1);
    mark();
    ready_mode = 2;
    @(posedge clk); #1 fifo_full_uart = 1'b1;
    n = 0;
    while (rd_cnt - rd0 < 1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("edge_started", 32'(n < 200), 32'd1);
    check("edge_busy", 32'(busy), 32'd1);
    pulse_req();
    wait_done("edge");
    repeat (10) @(negedge clk);
    ready_mode = 0;
    check_full_burst("edge");
    fifo_full_uart = 1'b0;

    // randomized bursts on random channels
    for (int k = 0; k < 3; k++) begin
      upr = 8'($urandom_range(0, 3));
      rand_words();
      make_exp(upr[1:0]);
      mark();
      ready_mode = 2;
      pulse_req();
      wait_done("rnd");
      ready_mode = 0;
      check_full_burst("rnd");
    end

    // abort after two words: channel moves into SPI range
    upr = 8'd0;
    rand_words();
    make_exp(2'd0);
    mark();
    pulse_req();
    n = 0;
    while (words_sent != 16'd2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ab_reach", 32'(n < 200), 32'd1);
    upr = 8'h10;
    @(negedge clk);
    check("ab_pulse", 32'(abort), 32'd1);
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_words", 32'(words_sent), 32'd2);
    repeat (10) @(negedge clk);
    check("ab_rd", 32'(rd_cnt - rd0), 32'd2);
    check("ab_cnt", 32'(abort_cnt - abort0), 32'd1);
    check("ab_done", 32'(done_cnt - done0), 32'd0);
    check("ab_txv", 32'(tx_valid), 32'd0);
    check_bytes("ab", 5);

    // asynchronous reset while the high byte is presented
    upr = 8'd3;
    rand_words();
    make_exp(2'd3);
    mark();
    pulse_req();
    n = 0;
    while (!((rd_cnt - rd0 >= 1) && tx_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ar_reach", 32'(n < 200), 32'd1);
    check("ar_pre_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("ar_txv", 32'(tx_valid), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_rd_en", 32'(uart_fifo_rd_en), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    rand_words();
    make_exp(2'd3);
    mark();
    pulse_req();
    wait_done("ar_new");
    check_full_burst("ar_new");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_fifo_drain.md
Name: uart_fifo_drain

Overview:
- Drains one burst from the FIFO currently routed to the UART path (channels upr 0..3) and streams it to the UART transmitter as bytes.
- Sits directly downstream of the FIFO routing switch:
  - consumes its 16-bit UART data word and its selected-FIFO full flag;
  - produces the UART-side FIFO read enable that the switch steers to the selected FIFO.
- Each burst is sent as one header byte, then each word high byte first.

Parameters:
- BURST_LEN, 1024, words read per burst (2..65535).
- HDR_TAG, 4'hA, upper nibble of the header byte.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- upr  input  8  channel select, same value as driven to the switch
- fifo_full_uart  input  1  full flag of the selected FIFO
- uart_out  input  16  read data of the selected FIFO
- drain_req  input  1  one-cycle manual burst request
- tx_ready  input  1  UART TX can accept a byte
- uart_fifo_rd_en  output  1  FIFO read strobe, to the switch
- tx_data  output  8  byte to UART TX
- tx_valid  output  1  tx_data valid
- busy  output  1  burst in progress
- done  output  1  one-cycle pulse at normal burst end
- abort  output  1  one-cycle pulse when a burst is cancelled
- words_sent  output  16  words completed in the current or last burst

Behaviour:
- Clock and reset:
  - one clock, clk;
  - rst asynchronous, active-low: asserting it immediately clears all state; release is sampled on clk.
- Reset values:
  - all outputs 0;
  - state IDLE;
  - the latched channel is 0.
- Channel valid condition: upr <= 3.
- Burst start (IDLE only):
  - Start when the channel is valid and either drain_req = 1 or fifo_full_uart has a rising edge. The edge is detected against a registered copy of fifo_full_uart.
  - Latch upr[1:0] as ch, clear words_sent, assert busy.
  - A full flag that is already high at reset release does not start a burst.
- Byte handshake: a byte transfers on a clk edge with tx_valid = 1 and tx_ready = 1.
  - tx_valid stays high and tx_data stays stable until the transfer.
- States and transitions:
  - IDLE: wait for a start condition.
  - HDR: tx_data = {HDR_TAG, 2'b00, ch}, tx_valid = 1; on transfer go to RD.
  - RD: uart_fifo_rd_en = 1 for exactly one cycle, then go to LAT.
  - LAT: the FIFO has 1-cycle read latency, so capture uart_out into a 16-bit word register here; go to HI.
  - HI: tx_data = word[15:8], tx_valid = 1; on transfer go to LO.
  - LO: tx_data = word[7:0], tx_valid = 1; on transfer increment words_sent. Then go to DONE if words_sent + 1 == BURST_LEN, else go to RD.
  - DONE: pulse done for one cycle, clear busy, go to IDLE. words_sent holds its final value until the next start.
- Abort:
  - Trigger: in any non-IDLE state, upr != {6'b0, ch} (channel changed or moved to the SPI range).
  - Response: go to IDLE next cycle, pulse abort, clear busy and tx_valid.
  - No read strobe is issued in the abort cycle; a byte accepted in that same cycle still counts as transferred.
  - Abort takes priority over a simultaneous transfer-completion transition.
- Triggers while busy: drain_req and full edges are ignored, not queued.
- uart_fifo_rd_en is never high outside RD and is never asserted in two consecutive cycles.
- words_sent is 16-bit and saturates by construction because BURST_LEN <= 65535.
- Latency:
  - start to header tx_valid: 1 cycle;
  - header transfer to read strobe: 1 cycle;
  - read strobe to high-byte tx_valid: 2 cycles.

Decomposition:
- Shared package uart_drain_pkg:
  - state enum (IDLE, HDR, RD, LAT, HI, LO, DONE);
  - constant UART_CH_MAX = 3;
  - default BURST_LEN and HDR_TAG.
- One natural sub-module: edge_detect_rise (registered rising-edge detector for fifo_full_uart).
- Everything else lives in a single FSM plus datapath.

Test Plan:
- Reset/idle: hold rst = 0, drive fifo_full_uart = 1 and drain_req = 1 -> all outputs 0. After release with full still high, no burst starts.
- Normal burst: BURST_LEN = 4, upr = 2, drain_req pulse, FIFO model returns 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0 with 1-cycle latency, tx_ready = 1 -> bytes A2 12 34 56 78 9A BC DE F0, exactly 4 rd strobes, words_sent = 4, one done pulse.
- Backpressure: same burst with tx_ready toggling 1 cycle on / 3 cycles off -> identical byte sequence, tx_data stable while tx_valid = 1 and tx_ready = 0, no extra rd strobes.
- Full-edge trigger: upr = 1, fifo_full_uart rises 0 -> 1 -> burst starts with header A1. drain_req during the burst is ignored.
- Abort: upr changes 0 -> 8'h10 after 2 words sent -> abort pulse, busy = 0 next cycle, words_sent = 2, no further rd strobes or tx_valid.
- Async reset mid-burst: rst low during HI -> tx_valid, busy and uart_fifo_rd_en drop immediately without waiting for a clk edge; the next drain_req produces a fresh header.
